// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
//
// Shared core package for the write-back arbiter slice.
//
// Contents:
//   WB_ARB_DEPTH_DEFAULT         default number of MDU result buffer entries
//   WB_ARB_STARVE_LIMIT_DEFAULT  default blocked-cycle count before the MDU
//                                result is forced onto the register-file port
//   wb_arb_entry_t               one buffered MDU result (rd, data, valid, kill)
//   entry_live_match()           hazard lookup helper: entry holds a write
//                                that is still going to land on register rs
//
// Used by: wb_arb_buf, wb_arbiter
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int WB_ARB_DEPTH_DEFAULT        = 2;
    localparam int WB_ARB_STARVE_LIMIT_DEFAULT = 8;

    // One MDU result waiting for a register-file write slot. A killed entry
    // still occupies its slot and drains in order, but never writes.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        valid;
        logic        kill;
    } wb_arb_entry_t;

    // True when an entry still owes a write to register rs.
    function automatic logic entry_live_match(
        input logic       valid,
        input logic       kill,
        input logic [4:0] rd,
        input logic [4:0] rs
    );
        return valid && !kill && (rd == rs);
    endfunction

endpackage

// File: rtl/wb_arb_buf.sv
// ---------------------------------------------------------------------------
// wb_arb_buf
//
// In-order result buffer for the multi-cycle unit (MDU). Holds results that
// could not reach the register file because the pipeline's own write-back
// owned the port. Entries are never reordered; a younger pipeline write to
// the same register marks older buffered results as killed so they drain
// without overwriting the newer value.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      synchronous active-high reset, empties the buffer
//   push       enqueue {push_rd, push_data} at the tail (ignored when full)
//   push_rd    destination register of the incoming result
//   push_data  incoming result data
//   pop        drop the head entry (ignored when empty)
//   kill_en    a pipeline write to kill_rd is being performed this cycle
//   kill_rd    register written by the pipeline this cycle
//   rs1, rs2   hazard lookup registers
//   empty      no entries held
//   full       DEPTH entries held
//   head_rd    destination register of the head entry
//   head_data  data of the head entry
//   head_kill  head entry has been superseded and must not write
//   hit1, hit2 rsN != 0 and matches a live entry or the incoming push
// ---------------------------------------------------------------------------
module wb_arb_buf
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_ARB_DEPTH_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [4:0]  push_rd,
    input  logic [31:0] push_data,
    input  logic        pop,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        empty,
    output logic        full,
    output logic [4:0]  head_rd,
    output logic [31:0] head_data,
    output logic        head_kill,
    output logic        hit1,
    output logic        hit2
);

    localparam int PW = $clog2(DEPTH);

    wb_arb_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    assign head_rd   = mem[rd_ptr].rd;
    assign head_data = mem[rd_ptr].data;
    assign head_kill = mem[rd_ptr].kill;

    // Hazard lookup. A result being accepted this cycle is already a pending
    // write from the hazard unit's point of view, so it is included before it
    // lands in storage. Register 0 is never pending.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live_match(mem[i].valid, mem[i].kill, mem[i].rd, rs1)) begin
                hit1 = 1'b1;
            end
            if (entry_live_match(mem[i].valid, mem[i].kill, mem[i].rd, rs2)) begin
                hit2 = 1'b1;
            end
        end
        if (push_ok && (push_rd == rs1)) begin
            hit1 = 1'b1;
        end
        if (push_ok && (push_rd == rs2)) begin
            hit2 = 1'b1;
        end
        if (rs1 == 5'd0) begin
            hit1 = 1'b0;
        end
        if (rs2 == 5'd0) begin
            hit2 = 1'b0;
        end
    end

    // Storage, pointers and occupancy. Kill marking runs first so a later
    // pop of the same slot still clears it; an entry pushed in the same cycle
    // as a matching pipeline write is born killed. Push and pop never target
    // the same slot: that would need the buffer to be both empty and full.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].valid && (mem[i].rd == kill_rd)) begin
                    mem[i].kill <= 1'b1;
                end
            end
            if (pop_ok) begin
                mem[rd_ptr].valid <= 1'b0;
                mem[rd_ptr].kill  <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                mem[wr_ptr].rd    <= push_rd;
                mem[wr_ptr].data  <= push_data;
                mem[wr_ptr].valid <= 1'b1;
                mem[wr_ptr].kill  <= kill_en && (kill_rd == push_rd);
                wr_ptr            <= wr_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Register-file write-port arbiter between the pipeline write-back stage and
// a multi-cycle unit (MDU). The pipeline normally owns the single write port;
// MDU results queue in wb_arb_buf and drain in idle slots. A pipeline write
// that lands on a register with an older buffered MDU result kills that
// result so the architecturally newer value survives.
//
// Optional feature (define WB_ARB_STARVE_EN to enable):
//   A starvation counter counts cycles in which buffered results were blocked.
//   When it reaches STARVE_LIMIT-1 the head result is forced onto the port and
//   the pipeline is stalled for that cycle. Without the macro the pipeline
//   always wins and pipe_stall is tied low.
//
// Parameters:
//   DEPTH         MDU result buffer entries (power of two, >= 2)
//   STARVE_LIMIT  blocked cycles before the MDU is forced onto the port
//
// Ports:
//   clk                      clock, all state updates on rising edge
//   reset                    synchronous active-high reset
//   pipe_regwrite            wb stage write request
//   pipe_rd, pipe_result     wb stage destination register / write data
//   mdu_valid                MDU result valid
//   mdu_rd, mdu_result       MDU destination register / write data
//   mdu_ready                buffer can accept an MDU result this cycle
//   hz_rs1, hz_rs2           hazard-unit lookup registers
//   hz_pending1, hz_pending2 lookup register has a buffered write pending
//   rf_we, rf_rd, rf_wdata   register-file write port
//   pipe_stall               pipeline must hold its wb contents this cycle
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = WB_ARB_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = WB_ARB_STARVE_LIMIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_regwrite,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_result,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_result,
    output logic        mdu_ready,
    input  logic [4:0]  hz_rs1,
    input  logic [4:0]  hz_rs2,
    output logic        hz_pending1,
    output logic        hz_pending2,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall
);

    logic        buf_empty;
    logic        buf_full;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic        head_kill;
    logic        hit1;
    logic        hit2;
    logic        push;
    logic        pipe_live;
    logic        forced;
    logic        pipe_grant;
    logic        head_grant;

    wb_arb_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (mdu_rd),
        .push_data (mdu_result),
        .pop       (head_grant),
        .kill_en   (pipe_grant),
        .kill_rd   (pipe_rd),
        .rs1       (hz_rs1),
        .rs2       (hz_rs2),
        .empty     (buf_empty),
        .full      (buf_full),
        .head_rd   (head_rd),
        .head_data (head_data),
        .head_kill (head_kill),
        .hit1      (hit1),
        .hit2      (hit2)
    );

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // Counts consecutive cycles where a buffered result waited. The count
    // restarts whenever the head gets the port or nothing is waiting, so a
    // single forced cycle is enough to guarantee forward progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (buf_empty || head_grant) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign forced = !reset && !buf_empty && (starve_cnt == SW'(STARVE_LIMIT - 1));
`else
    assign forced = 1'b0;
`endif

    // Port arbitration: forced MDU > live pipeline write > buffer head.
    // A forced cycle stalls the pipeline, so its write neither lands nor
    // kills anything; it will be replayed next cycle. A killed head still
    // pops when granted, just without asserting the write enable.
    always_comb begin
        mdu_ready  = !buf_full && !reset;
        push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
        pipe_live  = pipe_regwrite && (pipe_rd != 5'd0);
        pipe_grant = !reset && pipe_live && !forced;
        head_grant = !reset && !buf_empty && (forced || !pipe_live);

        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_grant) begin
            rf_we    = 1'b1;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_result;
        end else if (head_grant) begin
            rf_we    = !head_kill;
            rf_rd    = head_rd;
            rf_wdata = head_data;
        end

        pipe_stall  = forced;
        hz_pending1 = hit1 && !reset;
        hz_pending2 = hit2 && !reset;
    end

endmodule
